// File: rtl/rf_arb_pkg.sv
// Shared types for the HMC register-file access arbiter.
// Holds the FSM state encoding, the response status codes and the timeout counter width.
package rf_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } rf_arb_state_t;

  typedef enum logic [1:0] {
    RF_OK      = 2'b00,
    RF_INVALID = 2'b01,
    RF_TIMEOUT = 2'b10
  } rf_rsp_status_t;

  // Wide enough for the largest supported TIMEOUT_CYCLES (65535).
  localparam int RF_TMO_CNT_W = 16;

endpackage

// File: rtl/rr_arbiter.sv
// One-hot round-robin grant: the lowest requester at or above ptr wins,
// otherwise the search wraps around to the lowest requester overall.
module rr_arbiter #(
  parameter int N  = 2,
  parameter int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  grant
);

  logic [N-1:0] mask;
  logic [N-1:0] masked;
  logic [N-1:0] pick;

  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_mask
      assign mask[gi] = (PW'(gi) >= ptr);
    end
  endgenerate

  assign masked = req & mask;
  assign pick   = (|masked) ? masked : req;
  // Isolate the lowest set bit of the candidate vector.
  assign grant  = pick & (~pick + N'(1));

endmodule

// File: rtl/rf_access_arbiter.sv
// Shares the single HMC register-file port between NUM_REQ requesters: round-robin
// grant, one outstanding access, completion/invalid/timeout folded into one response.
module rf_access_arbiter
  import rf_arb_pkg::*;
#(
  parameter int NUM_REQ        = 2,
  parameter int HMC_RF_WWIDTH  = 64,
  parameter int HMC_RF_RWIDTH  = 64,
  parameter int HMC_RF_AWIDTH  = 4,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                               clk_hmc,
  input  logic                               res_hmc,
  input  logic [NUM_REQ-1:0]                 req_valid,
  input  logic [NUM_REQ-1:0]                 req_write,
  input  logic [NUM_REQ*HMC_RF_AWIDTH-1:0]   req_addr,
  input  logic [NUM_REQ*HMC_RF_WWIDTH-1:0]   req_wdata,
  output logic [NUM_REQ-1:0]                 req_ready,
  output logic [NUM_REQ-1:0]                 rsp_valid,
  output logic [HMC_RF_RWIDTH-1:0]           rsp_rdata,
  output logic [1:0]                         rsp_status,
  output logic [HMC_RF_AWIDTH-1:0]           rf_address,
  output logic [HMC_RF_WWIDTH-1:0]           rf_write_data,
  output logic                               rf_read_en,
  output logic                               rf_write_en,
  input  logic [HMC_RF_RWIDTH-1:0]           rf_read_data,
  input  logic                               rf_access_complete,
  input  logic                               rf_invalid_address,
  output logic                               busy,
  output logic                               spurious_err
);

  localparam int IW = $clog2(NUM_REQ);
  localparam int CW = RF_TMO_CNT_W;

  rf_arb_state_t             state_q, state_d;
  logic [IW-1:0]             ptr_q, ptr_d;
  logic [IW-1:0]             gnt_idx_q, gnt_idx_d;
  logic                      is_write_q, is_write_d;
  logic [HMC_RF_AWIDTH-1:0]  rf_address_q, rf_address_d;
  logic [HMC_RF_WWIDTH-1:0]  rf_write_data_q, rf_write_data_d;
  logic                      rf_read_en_q, rf_read_en_d;
  logic                      rf_write_en_q, rf_write_en_d;
  logic [CW-1:0]             tmo_cnt_q, tmo_cnt_d;
  logic [NUM_REQ-1:0]        rsp_valid_q, rsp_valid_d;
  logic [HMC_RF_RWIDTH-1:0]  rsp_rdata_q, rsp_rdata_d;
  rf_rsp_status_t            rsp_status_q, rsp_status_d;
  logic                      spurious_q, spurious_d;

  logic [NUM_REQ-1:0]        grant;
  logic [IW-1:0]             win_idx;
  logic [HMC_RF_AWIDTH-1:0]  addr_arr  [NUM_REQ];
  logic [HMC_RF_WWIDTH-1:0]  wdata_arr [NUM_REQ];
  logic                      rf_event;
  rf_rsp_status_t            fin_status;
  logic [HMC_RF_RWIDTH-1:0]  fin_rdata;
  logic                      rsp_take;

  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
      assign addr_arr[gi]  = req_addr[gi*HMC_RF_AWIDTH +: HMC_RF_AWIDTH];
      assign wdata_arr[gi] = req_wdata[gi*HMC_RF_WWIDTH +: HMC_RF_WWIDTH];
    end
  endgenerate

  rr_arbiter #(
    .N  (NUM_REQ),
    .PW (IW)
  ) u_rr (
    .req   (req_valid),
    .ptr   (ptr_q),
    .grant (grant)
  );

  always_comb begin
    win_idx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) win_idx = IW'(i);
    end
  end

  // Any RF handshake; outside ISSUE/WAIT it is unexpected and only flagged.
  assign rf_event = rf_access_complete | rf_invalid_address;

  // Outcome of a completion: INVALID dominates, write responses carry no data.
  always_comb begin
    fin_status = RF_OK;
    fin_rdata  = '0;
    if (rf_invalid_address) begin
      fin_status = RF_INVALID;
    end else if (!is_write_q) begin
      fin_rdata = rf_read_data;
    end
  end

  always_comb begin
    state_d         = state_q;
    ptr_d           = ptr_q;
    gnt_idx_d       = gnt_idx_q;
    is_write_d      = is_write_q;
    rf_address_d    = rf_address_q;
    rf_write_data_d = rf_write_data_q;
    rf_read_en_d    = 1'b0;
    rf_write_en_d   = 1'b0;
    tmo_cnt_d       = tmo_cnt_q;
    rsp_valid_d     = '0;
    rsp_rdata_d     = rsp_rdata_q;
    rsp_status_d    = rsp_status_q;
    spurious_d      = spurious_q;
    rsp_take        = 1'b0;

    case (state_q)
      IDLE: begin
        spurious_d = spurious_q | rf_event;
        if (|grant) begin
          gnt_idx_d       = win_idx;
          is_write_d      = req_write[win_idx];
          rf_address_d    = addr_arr[win_idx];
          rf_write_data_d = wdata_arr[win_idx];
          rf_read_en_d    = ~req_write[win_idx];
          rf_write_en_d   = req_write[win_idx];
          state_d         = ISSUE;
        end
      end
      ISSUE: begin
        if (rf_event) begin
          rsp_status_d = fin_status;
          rsp_rdata_d  = fin_rdata;
          rsp_take     = 1'b1;
        end else begin
          tmo_cnt_d = '0;
          state_d   = WAIT;
        end
      end
      WAIT: begin
        tmo_cnt_d = tmo_cnt_q + CW'(1);
        if (rf_event) begin
          rsp_status_d = fin_status;
          rsp_rdata_d  = fin_rdata;
          rsp_take     = 1'b1;
        end else if (tmo_cnt_d == CW'(TIMEOUT_CYCLES)) begin
          rsp_status_d = RF_TIMEOUT;
          rsp_rdata_d  = '0;
          rsp_take     = 1'b1;
        end
      end
      RESP: begin
        spurious_d = spurious_q | rf_event;
        ptr_d      = (gnt_idx_q == IW'(NUM_REQ - 1)) ? '0 : gnt_idx_q + IW'(1);
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (rsp_take) begin
      rsp_valid_d = NUM_REQ'(1) << gnt_idx_q;
      state_d     = RESP;
    end
  end

  always_ff @(posedge clk_hmc) begin
    if (res_hmc) begin
      state_q         <= IDLE;
      ptr_q           <= '0;
      gnt_idx_q       <= '0;
      is_write_q      <= 1'b0;
      rf_address_q    <= '0;
      rf_write_data_q <= '0;
      rf_read_en_q    <= 1'b0;
      rf_write_en_q   <= 1'b0;
      tmo_cnt_q       <= '0;
      rsp_valid_q     <= '0;
      rsp_rdata_q     <= '0;
      rsp_status_q    <= RF_OK;
      spurious_q      <= 1'b0;
    end else begin
      state_q         <= state_d;
      ptr_q           <= ptr_d;
      gnt_idx_q       <= gnt_idx_d;
      is_write_q      <= is_write_d;
      rf_address_q    <= rf_address_d;
      rf_write_data_q <= rf_write_data_d;
      rf_read_en_q    <= rf_read_en_d;
      rf_write_en_q   <= rf_write_en_d;
      tmo_cnt_q       <= tmo_cnt_d;
      rsp_valid_q     <= rsp_valid_d;
      rsp_rdata_q     <= rsp_rdata_d;
      rsp_status_q    <= rsp_status_d;
      spurious_q      <= spurious_d;
    end
  end

  assign req_ready     = (state_q == IDLE && !res_hmc) ? grant : '0;
  assign rsp_valid     = rsp_valid_q;
  assign rsp_rdata     = rsp_rdata_q;
  assign rsp_status    = rsp_status_q;
  assign rf_address    = rf_address_q;
  assign rf_write_data = rf_write_data_q;
  assign rf_read_en    = rf_read_en_q;
  assign rf_write_en   = rf_write_en_q;
  assign busy          = (state_q != IDLE);
  assign spurious_err  = spurious_q;

endmodule

// File: tb/tb_rf_access_arbiter.sv
// Self-checking bench for rf_access_arbiter: directed scenarios plus a randomized run
// checked against a transaction-level model of grant order, latency and response outcome.
module tb_rf_access_arbiter;

  localparam int N  = 2;
  localparam int WW = 64;
  localparam int RW = 64;
  localparam int AW = 4;
  localparam int TO = 4;

  logic              clk_hmc = 1'b0;
  logic              res_hmc;
  logic [N-1:0]      req_valid, req_write;
  logic [N*AW-1:0]   req_addr;
  logic [N*WW-1:0]   req_wdata;
  logic [N-1:0]      req_ready, rsp_valid;
  logic [RW-1:0]     rsp_rdata;
  logic [1:0]        rsp_status;
  logic [AW-1:0]     rf_address;
  logic [WW-1:0]     rf_write_data;
  logic              rf_read_en, rf_write_en;
  logic [RW-1:0]     rf_read_data;
  logic              rf_access_complete, rf_invalid_address;
  logic              busy, spurious_err;

  int vectors     = 0;
  int miscompares = 0;

  rf_access_arbiter #(
    .NUM_REQ        (N),
    .HMC_RF_WWIDTH  (WW),
    .HMC_RF_RWIDTH  (RW),
    .HMC_RF_AWIDTH  (AW),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk_hmc            (clk_hmc),
    .res_hmc            (res_hmc),
    .req_valid          (req_valid),
    .req_write          (req_write),
    .req_addr           (req_addr),
    .req_wdata          (req_wdata),
    .req_ready          (req_ready),
    .rsp_valid          (rsp_valid),
    .rsp_rdata          (rsp_rdata),
    .rsp_status         (rsp_status),
    .rf_address         (rf_address),
    .rf_write_data      (rf_write_data),
    .rf_read_en         (rf_read_en),
    .rf_write_en        (rf_write_en),
    .rf_read_data       (rf_read_data),
    .rf_access_complete (rf_access_complete),
    .rf_invalid_address (rf_invalid_address),
    .busy               (busy),
    .spurious_err       (spurious_err)
  );

  always #5 clk_hmc = ~clk_hmc;

  // Inputs change 1 time unit after the rising edge; outputs are sampled 2 units later.
  task automatic tick();
    @(posedge clk_hmc);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic quiet();
    req_valid          = '0;
    req_write          = '0;
    rf_access_complete = 1'b0;
    rf_invalid_address = 1'b0;
    rf_read_data       = 64'h0BAD_0BAD_0BAD_0BAD;
  endtask

  task automatic set_req(input int r, input bit wr, input logic [AW-1:0] a, input logic [WW-1:0] d);
    req_valid[r]          = 1'b1;
    req_write[r]          = wr;
    req_addr[r*AW +: AW]  = a;
    req_wdata[r*WW +: WW] = d;
  endtask

  task automatic test_reset();
    tick(); res_hmc = 1'b1; req_valid = '1; req_write = 2'b10; rf_access_complete = 1'b1; settle();
    vectors++; if (req_ready !== 2'b00) begin miscompares++; $display("FAIL reset_ready got %b want 00", req_ready); end
    tick(); settle();
    vectors++; if ({rf_read_en, rf_write_en} !== 2'b00) begin miscompares++; $display("FAIL reset_rf_en got %b want 00", {rf_read_en, rf_write_en}); end
    vectors++; if ({rf_address, rf_write_data} !== '0) begin miscompares++; $display("FAIL reset_rf_bus got %h/%h want 0", rf_address, rf_write_data); end
    vectors++; if ({rsp_valid, rsp_status, rsp_rdata} !== '0) begin miscompares++; $display("FAIL reset_rsp got %b/%b/%h want 0", rsp_valid, rsp_status, rsp_rdata); end
    vectors++; if ({busy, spurious_err} !== 2'b00) begin miscompares++; $display("FAIL reset_flags got busy=%b spur=%b want 0/0", busy, spurious_err); end
    tick(); res_hmc = 1'b0; quiet(); settle();
    $display("reset: outputs cleared");
  endtask

  task automatic test_single_read();
    tick(); quiet(); set_req(0, 1'b0, 4'd3, 64'h1111_2222_3333_4444); settle();
    vectors++; if (req_ready !== 2'b01) begin miscompares++; $display("FAIL rd_ready got %b want 01", req_ready); end
    tick(); quiet(); rf_access_complete = 1'b1; rf_read_data = 64'hDEAD_BEEF_0000_0001; settle();
    vectors++; if ({rf_read_en, rf_write_en} !== 2'b10) begin miscompares++; $display("FAIL rd_en got %b want 10", {rf_read_en, rf_write_en}); end
    vectors++; if (rf_address !== 4'd3) begin miscompares++; $display("FAIL rd_addr got %h want 3", rf_address); end
    vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL rd_busy got %b want 1", busy); end
    tick(); quiet(); settle();
    vectors++; if (rsp_valid !== 2'b01) begin miscompares++; $display("FAIL rd_rsp_valid got %b want 01", rsp_valid); end
    vectors++; if (rsp_status !== 2'b00) begin miscompares++; $display("FAIL rd_status got %b want 00", rsp_status); end
    vectors++; if (rsp_rdata !== 64'hDEAD_BEEF_0000_0001) begin miscompares++; $display("FAIL rd_data got %h want deadbeef00000001", rsp_rdata); end
    vectors++; if (rf_read_en !== 1'b0) begin miscompares++; $display("FAIL rd_en_drop got %b want 0", rf_read_en); end
    tick(); quiet(); settle();
    vectors++; if (rsp_valid !== 2'b00) begin miscompares++; $display("FAIL rd_rsp_pulse got %b want 00", rsp_valid); end
    vectors++; if (rsp_rdata !== 64'hDEAD_BEEF_0000_0001) begin miscompares++; $display("FAIL rd_data_hold got %h want deadbeef00000001", rsp_rdata); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL rd_idle got busy=%b want 0", busy); end
    $display("single read: req0 addr 3 -> data %h status %b", rsp_rdata, rsp_status);
  endtask

  task automatic test_contention();
    logic [N-1:0]  exp_rdy, exp_rsp;
    logic [RW-1:0] exp_dat;
    tick(); res_hmc = 1'b1; quiet(); settle();
    for (int c = 0; c < 12; c++) begin
      tick(); res_hmc = 1'b0; quiet();
      set_req(0, 1'b0, 4'd1, '0);
      set_req(1, 1'b0, 4'd2, '0);
      rf_access_complete = (c % 3 == 1);
      rf_read_data = 64'hC0DE_0000_0000_0000 | 64'(c);
      settle();
      exp_rdy = (c % 3 == 0) ? (N'(1) << ((c / 3) % 2)) : '0;
      exp_rsp = (c % 3 == 2) ? (N'(1) << ((c / 3) % 2)) : '0;
      exp_dat = 64'hC0DE_0000_0000_0000 | 64'(c - 1);
      vectors++; if (req_ready !== exp_rdy) begin miscompares++; $display("FAIL cont_ready c=%0d got %b want %b", c, req_ready, exp_rdy); end
      vectors++; if (rsp_valid !== exp_rsp) begin miscompares++; $display("FAIL cont_rsp c=%0d got %b want %b", c, rsp_valid, exp_rsp); end
      if (c % 3 == 2) begin
        vectors++; if (rsp_rdata !== exp_dat) begin miscompares++; $display("FAIL cont_data c=%0d got %h want %h", c, rsp_rdata, exp_dat); end
        $display("contention: cycle %0d response to req %0d data %h", c, (c / 3) % 2, rsp_rdata);
      end
    end
  endtask

  task automatic test_invalid();
    tick(); quiet(); set_req(0, 1'b1, 4'd15, 64'hFEED_FACE_1234_5678); settle();
    vectors++; if (req_ready !== 2'b01) begin miscompares++; $display("FAIL inv_ready got %b want 01", req_ready); end
    tick(); quiet(); settle();
    vectors++; if ({rf_read_en, rf_write_en} !== 2'b01) begin miscompares++; $display("FAIL inv_en got %b want 01", {rf_read_en, rf_write_en}); end
    vectors++; if (rf_address !== 4'd15) begin miscompares++; $display("FAIL inv_addr got %h want f", rf_address); end
    vectors++; if (rf_write_data !== 64'hFEED_FACE_1234_5678) begin miscompares++; $display("FAIL inv_wdata got %h want feedface12345678", rf_write_data); end
    tick(); quiet(); settle();
    vectors++; if ({rsp_valid, busy} !== 3'b001) begin miscompares++; $display("FAIL inv_wait1 got rsp=%b busy=%b want 00/1", rsp_valid, busy); end
    tick(); quiet(); rf_invalid_address = 1'b1; rf_access_complete = 1'b1; rf_read_data = 64'h5555_5555_5555_5555; settle();
    vectors++; if (rsp_valid !== 2'b00) begin miscompares++; $display("FAIL inv_wait2 got %b want 00", rsp_valid); end
    tick(); quiet(); settle();
    vectors++; if (rsp_valid !== 2'b01) begin miscompares++; $display("FAIL inv_rsp got %b want 01", rsp_valid); end
    vectors++; if (rsp_status !== 2'b01) begin miscompares++; $display("FAIL inv_status got %b want 01", rsp_status); end
    vectors++; if (rsp_rdata !== 64'd0) begin miscompares++; $display("FAIL inv_data got %h want 0", rsp_rdata); end
    $display("invalid: write addr 15 -> status %b data %h", rsp_status, rsp_rdata);
  endtask

  task automatic test_timeout();
    tick(); quiet(); set_req(1, 1'b0, 4'd7, '0); settle();
    vectors++; if (req_ready !== 2'b10) begin miscompares++; $display("FAIL to_ready got %b want 10", req_ready); end
    for (int k = 1; k <= 1 + TO; k++) begin
      tick(); quiet(); settle();
      vectors++; if (rsp_valid !== 2'b00) begin miscompares++; $display("FAIL to_early k=%0d got %b want 00", k, rsp_valid); end
    end
    tick(); quiet(); settle();
    vectors++; if (rsp_valid !== 2'b10) begin miscompares++; $display("FAIL to_rsp got %b want 10", rsp_valid); end
    vectors++; if (rsp_status !== 2'b10) begin miscompares++; $display("FAIL to_status got %b want 10", rsp_status); end
    vectors++; if (rsp_rdata !== 64'd0) begin miscompares++; $display("FAIL to_data got %h want 0", rsp_rdata); end
    vectors++; if (spurious_err !== 1'b0) begin miscompares++; $display("FAIL to_spur_early got %b want 0", spurious_err); end
    tick(); quiet(); settle();
    tick(); quiet(); rf_access_complete = 1'b1; rf_read_data = 64'h7777_7777_7777_7777; settle();
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL to_idle got busy=%b want 0", busy); end
    tick(); quiet(); settle();
    vectors++; if (spurious_err !== 1'b1) begin miscompares++; $display("FAIL to_spur got %b want 1", spurious_err); end
    vectors++; if ({rsp_valid, rsp_rdata} !== '0) begin miscompares++; $display("FAIL to_late got rsp=%b data=%h want 0", rsp_valid, rsp_rdata); end
    $display("timeout: req1 read -> status 10, late completion flagged spurious=%b", spurious_err);
  endtask

  task automatic test_reset_midop();
    tick(); quiet(); set_req(0, 1'b0, 4'd1, '0); settle();
    tick(); quiet(); rf_access_complete = 1'b1; settle();
    tick(); quiet(); settle();
    vectors++; if (rsp_valid !== 2'b01) begin miscompares++; $display("FAIL mid_pre_rsp got %b want 01", rsp_valid); end
    tick(); quiet(); set_req(1, 1'b0, 4'd9, '0); settle();
    vectors++; if (req_ready !== 2'b10) begin miscompares++; $display("FAIL mid_ready got %b want 10", req_ready); end
    tick(); quiet(); settle();
    vectors++; if (rf_read_en !== 1'b1) begin miscompares++; $display("FAIL mid_en got %b want 1", rf_read_en); end
    tick(); quiet(); settle();
    tick(); quiet(); res_hmc = 1'b1; req_valid = '1; settle();
    vectors++; if (req_ready !== 2'b00) begin miscompares++; $display("FAIL mid_ready_rst got %b want 00", req_ready); end
    tick(); res_hmc = 1'b0; quiet(); set_req(0, 1'b0, 4'd4, '0); set_req(1, 1'b0, 4'd5, '0); settle();
    vectors++; if ({rf_read_en, rf_write_en, rf_address} !== '0) begin miscompares++; $display("FAIL mid_rf got en=%b addr=%h want 0", {rf_read_en, rf_write_en}, rf_address); end
    vectors++; if ({rsp_valid, rsp_status, rsp_rdata} !== '0) begin miscompares++; $display("FAIL mid_rsp got %b/%b/%h want 0", rsp_valid, rsp_status, rsp_rdata); end
    vectors++; if ({busy, spurious_err} !== 2'b00) begin miscompares++; $display("FAIL mid_flags got busy=%b spur=%b want 0/0", busy, spurious_err); end
    vectors++; if (req_ready !== 2'b01) begin miscompares++; $display("FAIL mid_ptr got %b want 01", req_ready); end
    tick(); quiet(); rf_access_complete = 1'b1; rf_read_data = 64'hABCD_0000_0000_ABCD; settle();
    vectors++; if (rf_address !== 4'd4) begin miscompares++; $display("FAIL mid_addr got %h want 4", rf_address); end
    tick(); quiet(); settle();
    vectors++; if (rsp_valid !== 2'b01) begin miscompares++; $display("FAIL mid_rsp_after got %b want 01", rsp_valid); end
    vectors++; if (rsp_rdata !== 64'hABCD_0000_0000_ABCD) begin miscompares++; $display("FAIL mid_data got %h want abcd00000000abcd", rsp_rdata); end
    tick(); quiet(); settle();
    $display("reset mid-op: aborted req1, req0 served first afterwards");
  endtask

  // Model: one transaction in flight; accept when idle, respond after the RF delay
  // (or after the timeout), return to idle the cycle after the response.
  task automatic test_random();
    int idle_at, ptr, en, rc, ev_cyc, g, d, rsp_id, spur_from;
    bit wr, ev_comp, ev_inv, inv;
    logic [N-1:0]  exp_ready, exp_rsp;
    logic [1:0]    exp_st, exp_en;
    logic [RW-1:0] exp_rdata, ev_data;
    logic [AW-1:0] a;
    logic [WW-1:0] wd;
    tick(); res_hmc = 1'b1; quiet(); settle();
    idle_at = 0; ptr = 0; en = -1; rc = -1; ev_cyc = -1; rsp_id = 0; spur_from = 1 << 30;
    wr = 1'b0; ev_comp = 1'b0; ev_inv = 1'b0; a = '0; wd = '0; exp_st = 2'b00;
    exp_rdata = '0; ev_data = '0;
    for (int n = 0; n < 400; n++) begin
      tick(); res_hmc = 1'b0; quiet();
      for (int r = 0; r < N; r++) begin
        req_valid[r] = ($urandom % 3 != 0);
        req_write[r] = $urandom % 2;
        req_addr[r*AW +: AW] = AW'($urandom);
        req_wdata[r*WW +: WW] = {$urandom, $urandom};
      end
      if (n == ev_cyc) begin
        rf_access_complete = ev_comp;
        rf_invalid_address = ev_inv;
        rf_read_data       = ev_data;
      end else begin
        rf_read_data = {$urandom, $urandom};
      end
      exp_ready = '0;
      if (n >= idle_at) begin
        g = -1;
        for (int k = 0; k < N; k++) begin
          if (g < 0 && req_valid[(ptr + k) % N]) g = (ptr + k) % N;
        end
        if (g >= 0) begin
          exp_ready[g] = 1'b1;
          wr = req_write[g];
          a  = req_addr[g*AW +: AW];
          wd = req_wdata[g*WW +: WW];
          d   = $urandom_range(0, TO + 1);
          inv = ($urandom % 4 == 0);
          en = n + 1;
          ev_cyc = en + d;
          ev_data = {$urandom, $urandom};
          if (d <= TO) begin
            ev_inv  = inv;
            ev_comp = inv ? 1'($urandom % 2) : 1'b1;
            rc = en + d + 1;
            exp_st = inv ? 2'b01 : 2'b00;
            exp_rdata = (inv || wr) ? '0 : ev_data;
          end else begin
            ev_inv  = 1'b0;
            ev_comp = 1'b1;
            rc = en + TO + 1;
            exp_st = 2'b10;
            exp_rdata = '0;
            if (spur_from > rc + 1) spur_from = rc + 1;
          end
          rsp_id  = g;
          idle_at = rc + 1;
          ptr     = (g + 1) % N;
        end
      end
      settle();
      exp_rsp = (n == rc) ? (N'(1) << rsp_id) : '0;
      exp_en  = (n == en) ? {~wr, wr} : 2'b00;
      vectors++; if (req_ready !== exp_ready) begin miscompares++; $display("FAIL rnd_ready n=%0d got %b want %b", n, req_ready, exp_ready); end
      vectors++; if (rsp_valid !== exp_rsp) begin miscompares++; $display("FAIL rnd_rsp n=%0d got %b want %b", n, rsp_valid, exp_rsp); end
      vectors++; if ({rf_read_en, rf_write_en} !== exp_en) begin miscompares++; $display("FAIL rnd_en n=%0d got %b want %b", n, {rf_read_en, rf_write_en}, exp_en); end
      vectors++; if (busy !== (n >= en && n <= rc)) begin miscompares++; $display("FAIL rnd_busy n=%0d got %b want %b", n, busy, (n >= en && n <= rc)); end
      vectors++; if (spurious_err !== (n >= spur_from)) begin miscompares++; $display("FAIL rnd_spur n=%0d got %b want %b", n, spurious_err, (n >= spur_from)); end
      if (n == en) begin
        vectors++; if (rf_address !== a) begin miscompares++; $display("FAIL rnd_addr n=%0d got %h want %h", n, rf_address, a); end
        if (wr) begin
          vectors++; if (rf_write_data !== wd) begin miscompares++; $display("FAIL rnd_wdata n=%0d got %h want %h", n, rf_write_data, wd); end
        end
      end
      if (n == rc) begin
        vectors++; if (rsp_status !== exp_st) begin miscompares++; $display("FAIL rnd_status n=%0d got %b want %b", n, rsp_status, exp_st); end
        vectors++; if (rsp_rdata !== exp_rdata) begin miscompares++; $display("FAIL rnd_data n=%0d got %h want %h", n, rsp_rdata, exp_rdata); end
        $display("random: cycle %0d req %0d %s addr %h status %b data %h", n, rsp_id, wr ? "wr" : "rd", a, rsp_status, rsp_rdata);
      end
    end
  endtask

  initial begin
    res_hmc   = 1'b1;
    req_addr  = '0;
    req_wdata = '0;
    quiet();
    test_reset();
    test_single_read();
    test_contention();
    test_invalid();
    test_timeout();
    test_reset_midop();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired got running want finished");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/rf_access_arbiter.md
Name: rf_access_arbiter

Overview:
Shares the single HMC register-file access port (rf_address / rf_read_en / rf_write_en / rf_write_data / rf_read_data / rf_access_complete / rf_invalid_address) between NUM_REQ requesters, for example the host config master and the link-training sequencer.
The block arbitrates round-robin and issues one RF access at a time. It waits for completion, an invalid-address flag, or a timeout, then returns a per-requester response. It sits in the clk_hmc domain directly in front of the RF.

Parameters:
NUM_REQ, 2, number of requesters (2..8)
HMC_RF_WWIDTH, 64, write data width
HMC_RF_RWIDTH, 64, read data width
HMC_RF_AWIDTH, 4, RF address width
TIMEOUT_CYCLES, 255, maximum WAIT cycles before a timeout is declared (1..65535)

Ports:
clk_hmc  in  1  single clock, all logic on the rising edge
res_hmc  in  1  synchronous, active-high reset
req_valid  in  NUM_REQ  request pending, one bit per requester
req_write  in  NUM_REQ  1 = write, 0 = read
req_addr  in  NUM_REQ*HMC_RF_AWIDTH  flattened addresses; requester i occupies slice i
req_wdata  in  NUM_REQ*HMC_RF_WWIDTH  flattened write data
req_ready  out  NUM_REQ  one-hot; request accepted this cycle
rsp_valid  out  NUM_REQ  one-hot, one-cycle response pulse
rsp_rdata  out  HMC_RF_RWIDTH  read data, shared, valid with rsp_valid
rsp_status  out  2  00 OK, 01 INVALID, 10 TIMEOUT, valid with rsp_valid
rf_address  out  HMC_RF_AWIDTH  to RF
rf_write_data  out  HMC_RF_WWIDTH  to RF
rf_read_en  out  1  to RF
rf_write_en  out  1  to RF
rf_read_data  in  HMC_RF_RWIDTH  from RF
rf_access_complete  in  1  from RF
rf_invalid_address  in  1  from RF
busy  out  1  high in any state other than IDLE
spurious_err  out  1  sticky; RF completion seen while no access was outstanding

Behaviour:
- Reset
  - Registered outputs are 0: rf_*, rsp_*, spurious_err.
  - The state returns to IDLE and the round-robin pointer to 0.
  - req_ready is forced to 0 while res_hmc is high.
  - A reset asserted mid-access aborts it: no rsp_valid is produced and rf enables drop on the next edge.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE
  - If any req_valid is high, pick the winner g as the first valid requester at or after the pointer, wrapping modulo NUM_REQ.
  - req_ready[g] is a combinational output, high in that cycle only.
  - On the clock edge, latch g, req_write[g], req_addr[g] and req_wdata[g], then go to ISSUE.
- ISSUE (acceptance cycle T+1)
  - Exactly one of rf_read_en / rf_write_en is high for this single cycle.
  - rf_address and rf_write_data hold the latched values from T+1 until the cycle after RESP.
  - Completion inputs are already sampled in this state.
  - If no completion arrives, go to WAIT and clear the timeout counter.
- WAIT
  - The counter increments every cycle.
  - If both rf_invalid_address and rf_access_complete are high, INVALID wins.
  - rf_invalid_address: status INVALID, captured rdata = 0.
  - rf_access_complete alone: status OK; for a read, capture rf_read_data, for a write, rdata = 0.
  - If the counter reaches TIMEOUT_CYCLES with no completion: status TIMEOUT, rdata = 0.
  - Any of these outcomes moves the FSM to RESP.
- RESP
  - rsp_valid[g] is high for exactly 1 cycle, together with rsp_rdata and rsp_status.
  - The pointer becomes (g+1) mod NUM_REQ.
  - The next state is IDLE.
  - rsp_rdata and rsp_status hold their values until the next response.
- No backpressure on responses; each requester must accept rsp_valid whenever it arrives.
- Latency with completion in the ISSUE cycle: accept at T, rf enable at T+1, rsp_valid at T+2, next accept possible at T+3.
- A late completion arriving after a timeout, or any completion while in IDLE or RESP, is ignored for data and sets spurious_err. spurious_err is cleared only by reset.
- req_valid dropping while the request is not yet granted is legal; no request is latched for that requester.
- Addresses and data are passed through unmodified; no width conversion takes place.

Decomposition:
- Package rf_arb_pkg holds:
  - typedef enum logic [1:0] rf_arb_state_t {IDLE, ISSUE, WAIT, RESP}
  - typedef enum logic [1:0] rf_rsp_status_t {RF_OK = 2'b00, RF_INVALID = 2'b01, RF_TIMEOUT = 2'b10}
- Sub-module rr_arbiter (parameter N) provides the one-hot round-robin grant: inputs are request and pointer, output is grant.
- The FSM, latches, timeout counter and spurious-error logic live in rf_access_arbiter.

Test Plan:
- Single read: req 0 reads address 3; RF asserts complete at T+1 with data 64'hDEAD_BEEF_0000_0001 -> rf_read_en high at T+1 only, rsp_valid[0] at T+2 with status 00 and that data.
- Contention: both requesters valid at reset release, completion always immediate -> grants in order 0,1,0,1; the four accept cycles are 3 cycles apart; no rsp_valid on the wrong bit.
- Invalid address: write to address 15 with RF asserting rf_invalid_address and rf_access_complete together 2 cycles after the enable -> rsp_status 01, rsp_rdata 0.
- Timeout: TIMEOUT_CYCLES = 4, RF never responds -> rsp_status 10 exactly 4 WAIT cycles after ISSUE; a later rf_access_complete sets spurious_err = 1 and produces no rsp_valid.
- Reset mid-op: assert res_hmc during WAIT -> the next cycle all outputs are 0 and state is IDLE; after release, requester 0 is granted first.
